// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge control FSM: sequences APB setup/enable phases from qualified AHB transfers.
// Optional macro APB_PREADY_EN adds a Pready input that stretches ENABLE states.
module apb_fsm_controller (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        valid,
    input  logic        Hwrite,
    input  logic        Hwritereg,
    input  logic [31:0] Haddr,
    input  logic [31:0] Haddr1,
    input  logic [31:0] Haddr2,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Hwdata1,
    input  logic [2:0]  tempselx,
`ifdef APB_PREADY_EN
    input  logic        Pready,
`endif
    output logic [2:0]  Pselx,
    output logic        Penable,
    output logic        Pwrite,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Hreadyout
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WWAIT    = 3'd1;
    localparam logic [2:0] ST_READ     = 3'd2;
    localparam logic [2:0] ST_WRITE    = 3'd3;
    localparam logic [2:0] ST_WRITEP   = 3'd4;
    localparam logic [2:0] ST_RENABLE  = 3'd5;
    localparam logic [2:0] ST_WENABLE  = 3'd6;
    localparam logic [2:0] ST_WENABLEP = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [2:0]  sel1_q, sel2_q;
    logic [2:0]  pselx_q, pselx_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        hreadyout_q, hreadyout_d;
    logic        stall;

`ifdef APB_PREADY_EN
    assign stall = ~Pready;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (valid && Hwrite)       state_d = ST_WWAIT;
                else if (valid && !Hwrite) state_d = ST_READ;
                else                       state_d = ST_IDLE;
            end
            ST_WWAIT:  state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:   state_d = ST_RENABLE;
            ST_WRITEP: state_d = ST_WENABLEP;
            ST_WRITE:  state_d = valid ? ST_WENABLEP : ST_WENABLE;
            ST_RENABLE, ST_WENABLE: begin
                if (stall)                 state_d = state_q;
                else if (valid && !Hwrite) state_d = ST_READ;
                else if (valid && Hwrite)  state_d = ST_WWAIT;
                else                       state_d = ST_IDLE;
            end
            ST_WENABLEP: begin
                if (stall)                   state_d = state_q;
                else if (!Hwritereg)         state_d = ST_READ;
                else if (valid)              state_d = ST_WRITEP;
                else                         state_d = ST_WRITE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decided by the state being entered (and, for writes, where it came from).
    always_comb begin
        pselx_d     = pselx_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        hreadyout_d = hreadyout_q;
        case (state_d)
            ST_IDLE, ST_WWAIT: begin
                pselx_d     = 3'b000;
                penable_d   = 1'b0;
                hreadyout_d = 1'b1;
            end
            ST_READ: begin
                paddr_d     = Haddr;
                pselx_d     = tempselx;
                pwrite_d    = 1'b0;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end
            ST_WRITE, ST_WRITEP: begin
                if (state_q == ST_WENABLEP) begin
                    paddr_d  = Haddr2;
                    pwdata_d = Hwdata1;
                    pselx_d  = sel2_q;
                end else begin
                    paddr_d  = Haddr1;
                    pwdata_d = Hwdata;
                    pselx_d  = sel1_q;
                end
                pwrite_d    = 1'b1;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end
            default: begin
                // ENABLE states: a self-loop only happens while the slave is stalling.
                penable_d   = 1'b1;
                hreadyout_d = (state_d != state_q);
            end
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q     <= ST_IDLE;
            sel1_q      <= 3'b000;
            sel2_q      <= 3'b000;
            pselx_q     <= 3'b000;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'h0;
            pwdata_q    <= 32'h0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            sel1_q      <= tempselx;
            sel2_q      <= sel1_q;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign Pselx     = pselx_q;
    assign Penable   = penable_q;
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Hreadyout = hreadyout_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller; the AHB-side delay registers and slave decode are modelled here.
module tb_apb_fsm_controller;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        valid, Hwrite, Hwritereg;
    logic [31:0] Haddr, Haddr1, Haddr2, Hwdata, Hwdata1;
    logic [2:0]  tempselx;
    logic        Pready;
    logic [2:0]  Pselx;
    logic        Penable, Pwrite, Hreadyout;
    logic [31:0] Paddr, Pwdata;
    logic [5:0]  ctl;

    int errors = 0;
    int checks = 0;

    apb_fsm_controller dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid), .Hwrite(Hwrite), .Hwritereg(Hwritereg),
        .Haddr(Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata(Hwdata), .Hwdata1(Hwdata1),
        .tempselx(tempselx),
`ifdef APB_PREADY_EN
        .Pready(Pready),
`endif
        .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Hreadyout(Hreadyout)
    );

    always #5 Hclk = ~Hclk;

    // AHB slave pipeline registers feeding the bridge
    always @(posedge Hclk) begin
        Haddr1    <= Haddr;
        Haddr2    <= Haddr1;
        Hwdata1   <= Hwdata;
        Hwritereg <= Hwrite;
    end

    always_comb begin
        tempselx = 3'b000;
        if (Haddr >= 32'h8000_0000 && Haddr < 32'h8400_0000)      tempselx = 3'b001;
        else if (Haddr >= 32'h8400_0000 && Haddr < 32'h8800_0000) tempselx = 3'b010;
        else if (Haddr >= 32'h8800_0000 && Haddr < 32'h8C00_0000) tempselx = 3'b100;
    end

    // {Pselx, Penable, Pwrite, Hreadyout}
    assign ctl = {Pselx, Penable, Pwrite, Hreadyout};

    task automatic step;
        @(posedge Hclk);
        #1;
    endtask

    task automatic test_reset;
        Hresetn = 1'b0; valid = 1'b0; Hwrite = 1'b0; Haddr = 32'h0; Hwdata = 32'h0; Pready = 1'b1;
        #12;
        checks++; if (ctl !== 6'b000_0_0_1) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 6'b000_0_0_1); end
        checks++; if (Paddr !== 32'h0) begin errors++; $display("FAIL reset_paddr got %h exp %h", Paddr, 32'h0); end
        checks++; if (Pwdata !== 32'h0) begin errors++; $display("FAIL reset_pwdata got %h exp %h", Pwdata, 32'h0); end
        @(negedge Hclk);
        Hresetn = 1'b1;
    endtask

    task automatic test_read;
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8000_0010;
        step;
        checks++; if (ctl !== 6'b001_0_0_0) begin errors++; $display("FAIL read_setup_ctl got %b exp %b", ctl, 6'b001_0_0_0); end
        checks++; if (Paddr !== 32'h8000_0010) begin errors++; $display("FAIL read_setup_paddr got %h exp %h", Paddr, 32'h8000_0010); end
        valid = 1'b0;
        step;
        checks++; if (ctl !== 6'b001_1_0_1) begin errors++; $display("FAIL read_enable_ctl got %b exp %b", ctl, 6'b001_1_0_1); end
        checks++; if (Paddr !== 32'h8000_0010) begin errors++; $display("FAIL read_enable_paddr got %h exp %h", Paddr, 32'h8000_0010); end
        step;
        checks++; if (ctl !== 6'b000_0_0_1) begin errors++; $display("FAIL read_idle_ctl got %b exp %b", ctl, 6'b000_0_0_1); end
    endtask

    task automatic test_write;
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8400_0004;
        step;
        checks++; if (ctl !== 6'b000_0_0_1) begin errors++; $display("FAIL write_wwait_ctl got %b exp %b", ctl, 6'b000_0_0_1); end
        valid = 1'b0; Hwdata = 32'hDEAD_BEEF;
        step;
        checks++; if (ctl !== 6'b010_0_1_0) begin errors++; $display("FAIL write_setup_ctl got %b exp %b", ctl, 6'b010_0_1_0); end
        checks++; if (Paddr !== 32'h8400_0004) begin errors++; $display("FAIL write_setup_paddr got %h exp %h", Paddr, 32'h8400_0004); end
        checks++; if (Pwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_setup_pwdata got %h exp %h", Pwdata, 32'hDEAD_BEEF); end
        step;
        checks++; if (ctl !== 6'b010_1_1_1) begin errors++; $display("FAIL write_enable_ctl got %b exp %b", ctl, 6'b010_1_1_1); end
        checks++; if (Pwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_enable_pwdata got %h exp %h", Pwdata, 32'hDEAD_BEEF); end
        step;
        checks++; if (ctl !== 6'b000_0_1_1) begin errors++; $display("FAIL write_idle_ctl got %b exp %b", ctl, 6'b000_0_1_1); end
    endtask

    task automatic test_back_to_back;
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8800_0000;
        step;
        checks++; if (ctl !== 6'b000_0_1_1) begin errors++; $display("FAIL b2b_wwait_ctl got %b exp %b", ctl, 6'b000_0_1_1); end
        Haddr = 32'h8800_0004; Hwdata = 32'h1111_0000;
        step;
        checks++; if (ctl !== 6'b100_0_1_0) begin errors++; $display("FAIL b2b_writep_ctl got %b exp %b", ctl, 6'b100_0_1_0); end
        checks++; if (Paddr !== 32'h8800_0000) begin errors++; $display("FAIL b2b_writep_paddr got %h exp %h", Paddr, 32'h8800_0000); end
        checks++; if (Pwdata !== 32'h1111_0000) begin errors++; $display("FAIL b2b_writep_pwdata got %h exp %h", Pwdata, 32'h1111_0000); end
        valid = 1'b0; Hwdata = 32'h2222_0004;
        step;
        checks++; if (ctl !== 6'b100_1_1_1) begin errors++; $display("FAIL b2b_wenablep_ctl got %b exp %b", ctl, 6'b100_1_1_1); end
        step;
        checks++; if (ctl !== 6'b100_0_1_0) begin errors++; $display("FAIL b2b_write_ctl got %b exp %b", ctl, 6'b100_0_1_0); end
        checks++; if (Paddr !== 32'h8800_0004) begin errors++; $display("FAIL b2b_write_paddr got %h exp %h", Paddr, 32'h8800_0004); end
        checks++; if (Pwdata !== 32'h2222_0004) begin errors++; $display("FAIL b2b_write_pwdata got %h exp %h", Pwdata, 32'h2222_0004); end
        step;
        checks++; if (ctl !== 6'b100_1_1_1) begin errors++; $display("FAIL b2b_wenable_ctl got %b exp %b", ctl, 6'b100_1_1_1); end
        step;
        checks++; if (ctl !== 6'b000_0_1_1) begin errors++; $display("FAIL b2b_idle_ctl got %b exp %b", ctl, 6'b000_0_1_1); end
    endtask

    task automatic test_write_read;
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8400_0008;
        step;
        checks++; if (ctl !== 6'b000_0_1_1) begin errors++; $display("FAIL wr_wwait_ctl got %b exp %b", ctl, 6'b000_0_1_1); end
        Hwrite = 1'b0; Haddr = 32'h8000_0020; Hwdata = 32'h1234_5678;
        step;
        checks++; if (ctl !== 6'b010_0_1_0) begin errors++; $display("FAIL wr_writep_ctl got %b exp %b", ctl, 6'b010_0_1_0); end
        checks++; if (Paddr !== 32'h8400_0008) begin errors++; $display("FAIL wr_writep_paddr got %h exp %h", Paddr, 32'h8400_0008); end
        checks++; if (Pwdata !== 32'h1234_5678) begin errors++; $display("FAIL wr_writep_pwdata got %h exp %h", Pwdata, 32'h1234_5678); end
        valid = 1'b0;
        step;
        checks++; if (ctl !== 6'b010_1_1_1) begin errors++; $display("FAIL wr_wenablep_ctl got %b exp %b", ctl, 6'b010_1_1_1); end
        step;
        checks++; if (ctl !== 6'b001_0_0_0) begin errors++; $display("FAIL wr_read_ctl got %b exp %b", ctl, 6'b001_0_0_0); end
        checks++; if (Paddr !== 32'h8000_0020) begin errors++; $display("FAIL wr_read_paddr got %h exp %h", Paddr, 32'h8000_0020); end
        step;
        checks++; if (ctl !== 6'b001_1_0_1) begin errors++; $display("FAIL wr_renable_ctl got %b exp %b", ctl, 6'b001_1_0_1); end
        step;
        checks++; if (ctl !== 6'b000_0_0_1) begin errors++; $display("FAIL wr_idle_ctl got %b exp %b", ctl, 6'b000_0_0_1); end
    endtask

    task automatic test_reset_mid;
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8800_0010;
        step;
        valid = 1'b0; Hwdata = 32'hCAFE_F00D;
        step;
        step;
        checks++; if (ctl !== 6'b100_1_1_1) begin errors++; $display("FAIL rst_mid_wenable_ctl got %b exp %b", ctl, 6'b100_1_1_1); end
        #2 Hresetn = 1'b0;
        #1;
        checks++; if (ctl !== 6'b000_0_0_1) begin errors++; $display("FAIL rst_mid_async_ctl got %b exp %b", ctl, 6'b000_0_0_1); end
        checks++; if (Paddr !== 32'h0) begin errors++; $display("FAIL rst_mid_paddr got %h exp %h", Paddr, 32'h0); end
        checks++; if (Pwdata !== 32'h0) begin errors++; $display("FAIL rst_mid_pwdata got %h exp %h", Pwdata, 32'h0); end
        #3 Hresetn = 1'b1;
        step;
        checks++; if (ctl !== 6'b000_0_0_1) begin errors++; $display("FAIL rst_mid_after_ctl got %b exp %b", ctl, 6'b000_0_0_1); end
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8400_0040;
        step;
        checks++; if (ctl !== 6'b010_0_0_0) begin errors++; $display("FAIL rst_first_read_ctl got %b exp %b", ctl, 6'b010_0_0_0); end
        checks++; if (Paddr !== 32'h8400_0040) begin errors++; $display("FAIL rst_first_read_paddr got %h exp %h", Paddr, 32'h8400_0040); end
        valid = 1'b0;
        step;
        checks++; if (ctl !== 6'b010_1_0_1) begin errors++; $display("FAIL rst_first_renable_ctl got %b exp %b", ctl, 6'b010_1_0_1); end
        step;
        checks++; if (ctl !== 6'b000_0_0_1) begin errors++; $display("FAIL rst_first_idle_ctl got %b exp %b", ctl, 6'b000_0_0_1); end
    endtask

`ifdef APB_PREADY_EN
    task automatic test_pready;
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8800_0020;
        step;
        checks++; if (ctl !== 6'b100_0_0_0) begin errors++; $display("FAIL pready_setup_ctl got %b exp %b", ctl, 6'b100_0_0_0); end
        valid = 1'b0; Pready = 1'b0;
        step;
        checks++; if (ctl !== 6'b100_1_0_1) begin errors++; $display("FAIL pready_enable_ctl got %b exp %b", ctl, 6'b100_1_0_1); end
        for (int i = 0; i < 3; i++) begin
            step;
            checks++; if (ctl !== 6'b100_1_0_0) begin errors++; $display("FAIL pready_hold%0d_ctl got %b exp %b", i, ctl, 6'b100_1_0_0); end
            checks++; if (Paddr !== 32'h8800_0020) begin errors++; $display("FAIL pready_hold%0d_paddr got %h exp %h", i, Paddr, 32'h8800_0020); end
        end
        Pready = 1'b1;
        step;
        checks++; if (ctl !== 6'b000_0_0_1) begin errors++; $display("FAIL pready_done_ctl got %b exp %b", ctl, 6'b000_0_0_1); end
    endtask
`endif

    initial begin
        test_reset;
        test_read;
        test_write;
        test_back_to_back;
        test_write_read;
        test_reset_mid;
`ifdef APB_PREADY_EN
        test_pready;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
